// File: rtl/jtdsp16_pio_pkg.sv
// Shared constants and types for the DSP16 parallel I/O bridge:
// FIFO depth default, status/control bit positions and the status word packer.
package jtdsp16_pio_pkg;

  localparam int PIO_AW = 3;
  localparam int PIO_DW = 16;

  // status word bit positions (psel=1 read)
  localparam int ST_OUT_FULL = 0;
  localparam int ST_IN_EMPTY = 1;
  localparam int ST_UDF      = 2;
  localparam int ST_OVF      = 3;

  // control word bit positions (psel=1 write)
  localparam int CTL_CLR_OVF = 0;
  localparam int CTL_CLR_UDF = 1;
  localparam int CTL_IRQ_EN  = 2;

  typedef struct packed {
    logic ovf;
    logic udf;
    logic in_empty;
    logic out_full;
  } pio_status_t;

  function automatic logic [PIO_DW-1:0] status_word(input pio_status_t s);
    logic [PIO_DW-1:0] w;
    w              = '0;
    w[ST_OVF]      = s.ovf;
    w[ST_UDF]      = s.udf;
    w[ST_IN_EMPTY] = s.in_empty;
    w[ST_OUT_FULL] = s.out_full;
    return w;
  endfunction

endpackage

// File: rtl/jtdsp16_pio_fifo.sv
// Synchronous FIFO, 2^AW words. Full/empty come from AW+1-bit pointers; a push
// when full or a pop when empty is ignored, judged on the pre-edge state.
module jtdsp16_pio_fifo
  import jtdsp16_pio_pkg::*;
#(
  parameter int AW = PIO_AW,
  parameter int DW = PIO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage needs no reset: empty pointers hide stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtdsp16_pio.sv
// DSP16 parallel I/O bridge: DSP strobes push/pop two FIFOs that the host
// drains/fills through valid/ready streams, with sticky error flags and an IRQ.
module jtdsp16_pio
  import jtdsp16_pio_pkg::*;
#(
  parameter int AW = PIO_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [15:0] pbus_out,
  input  logic        pods_n,
  input  logic        pids_n,
  input  logic        psel,
  output logic [15:0] pbus_in,
  output logic        irq,
  input  logic        iack,
  output logic [15:0] hout_data,
  output logic        hout_valid,
  input  logic        hout_ready,
  input  logic [15:0] hin_data,
  input  logic        hin_valid,
  output logic        hin_ready,
  output logic        ovf,
  output logic        udf
);

  logic        pods_q, pods_d, pids_q, pids_d;
  logic        ovf_q, ovf_d, udf_q, udf_d;
  logic        irq_q, irq_d, irq_en_q, irq_en_d;
  logic        pods_end, pids_end;
  logic        out_push, out_pop, out_full, out_empty;
  logic        in_push, in_pop, in_full, in_empty;
  logic [15:0] in_head;
  pio_status_t st;

  // strobe end = rising edge of the active-low strobe, seen on cen cycles only
  assign pods_end = cen & pods_n & ~pods_q;
  assign pids_end = cen & pids_n & ~pids_q;

  assign out_push = pods_end & ~psel;
  assign out_pop  = ~out_empty & hout_ready;
  assign in_push  = hin_valid & ~in_full;
  assign in_pop   = pids_end & ~psel;

  jtdsp16_pio_fifo #(.AW(AW), .DW(16)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .pop   (out_pop),
    .din   (pbus_out),
    .dout  (hout_data),
    .full  (out_full),
    .empty (out_empty)
  );

  jtdsp16_pio_fifo #(.AW(AW), .DW(16)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .pop   (in_pop),
    .din   (hin_data),
    .dout  (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  assign hout_valid = ~out_empty;
  assign hin_ready  = ~in_full;
  assign ovf        = ovf_q;
  assign udf        = udf_q;
  assign irq        = irq_q;

  assign st = '{ovf: ovf_q, udf: udf_q, in_empty: in_empty, out_full: out_full};

  always_comb begin
    pbus_in = 16'h0000;
    if (psel)           pbus_in = status_word(st);
    else if (!in_empty) pbus_in = in_head;
  end

  always_comb begin
    pods_d   = pods_q;
    pids_d   = pids_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    irq_en_d = irq_en_q;
    irq_d    = irq_q;
    if (cen) begin
      pods_d = pods_n;
      pids_d = pids_n;
    end
    if (pods_end && psel) begin
      if (pbus_out[CTL_CLR_OVF]) ovf_d = 1'b0;
      if (pbus_out[CTL_CLR_UDF]) udf_d = 1'b0;
      irq_en_d = pbus_out[CTL_IRQ_EN];
    end
    if (out_push && out_full) ovf_d = 1'b1;
    if (in_pop && in_empty)   udf_d = 1'b1;
    // set follows the clear so a same-cycle set wins over iack
    if (cen && iack) irq_d = 1'b0;
    if (cen && irq_en_q && in_empty && in_push) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pods_q   <= 1'b1;
      pids_q   <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      pods_q   <= pods_d;
      pids_q   <= pids_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_jtdsp16_pio.sv
// Self-checking bench for jtdsp16_pio: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of both FIFOs and the flags.
module tb_jtdsp16_pio;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, cen, pods_n, pids_n, psel, iack, hout_ready, hin_valid;
  logic [15:0] pbus_out, hin_data;
  logic [15:0] pbus_in, hout_data;
  logic        irq, hout_valid, hin_ready, ovf, udf;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_out[$];
  logic [15:0] m_in[$];
  logic [15:0] got[$];
  bit m_ovf, m_udf, m_irq, m_irq_en, m_pods, m_pids;

  always #5 clk = ~clk;

  jtdsp16_pio #(.AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .pbus_out   (pbus_out),
    .pods_n     (pods_n),
    .pids_n     (pids_n),
    .psel       (psel),
    .pbus_in    (pbus_in),
    .irq        (irq),
    .iack       (iack),
    .hout_data  (hout_data),
    .hout_valid (hout_valid),
    .hout_ready (hout_ready),
    .hin_data   (hin_data),
    .hin_valid  (hin_valid),
    .hin_ready  (hin_ready),
    .ovf        (ovf),
    .udf        (udf)
  );

  // Reference behaviour for one clock edge, given the inputs currently applied.
  task automatic model_step();
    bit pods_end = cen && pods_n && !m_pods;
    bit pids_end = cen && pids_n && !m_pids;
    int out_pre  = m_out.size();
    int in_pre   = m_in.size();
    bit en_pre   = m_irq_en;
    if (rst) begin
      m_out.delete(); m_in.delete();
      m_ovf = 0; m_udf = 0; m_irq = 0; m_irq_en = 0; m_pods = 1; m_pids = 1;
    end else begin
      if (out_pre > 0 && hout_ready) void'(m_out.pop_front());
      if (pods_end && !psel) begin
        if (out_pre == DEPTH) m_ovf = 1;
        else m_out.push_back(pbus_out);
      end
      if (pods_end && psel) begin
        if (pbus_out[0]) m_ovf = 0;
        if (pbus_out[1]) m_udf = 0;
        m_irq_en = pbus_out[2];
      end
      if (pids_end && !psel) begin
        if (in_pre == 0) m_udf = 1;
        else void'(m_in.pop_front());
      end
      if (hin_valid && in_pre < DEPTH) m_in.push_back(hin_data);
      if (cen && iack) m_irq = 0;
      if (cen && en_pre && in_pre == 0 && m_in.size() > 0) m_irq = 1;
      if (cen) begin m_pods = pods_n; m_pids = pids_n; end
    end
  endtask

  task automatic tick();
    #1;
    if (!rst && hout_valid && hout_ready) got.push_back(hout_data);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; cen = 1; pods_n = 1; pids_n = 1; psel = 0; iack = 0;
    hout_ready = 0; hin_valid = 0; pbus_out = '0; hin_data = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0; got.delete();
  endtask

  task automatic dsp_write(input logic [15:0] d, input logic sel);
    psel = sel; pbus_out = d; pods_n = 0; tick();
    pods_n = 1; tick();
    psel = 0;
  endtask

  task automatic dsp_read();
    psel = 0; pids_n = 0; tick();
    pids_n = 1; tick();
  endtask

  task automatic host_push(input logic [15:0] d);
    hin_data = d; hin_valid = 1; tick(); hin_valid = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; pods_n = 0; hin_valid = 1; hin_data = 16'h1111; tick();
    pods_n = 1; pbus_out = 16'h2222; tick();
    rst = 0; hin_valid = 0; psel = 0; #1;
    checks++; if (hout_valid !== 1'b0) begin errors++; $display("FAIL reset_hout_valid got %b want 0", hout_valid); end
    checks++; if (hin_ready !== 1'b1) begin errors++; $display("FAIL reset_hin_ready got %b want 1", hin_ready); end
    checks++; if ({irq, ovf, udf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {irq, ovf, udf}); end
    checks++; if (pbus_in !== 16'h0000) begin errors++; $display("FAIL reset_pbus_in got %h want 0000", pbus_in); end
    psel = 1; #1;
    checks++; if (pbus_in !== 16'h0002) begin errors++; $display("FAIL reset_status got %h want 0002", pbus_in); end
    psel = 0; tick(); tick();
    checks++; if (hout_valid !== 1'b0) begin errors++; $display("FAIL reset_no_push got %b want 0", hout_valid); end
  endtask

  task automatic test_in_order();
    do_reset(); hout_ready = 1;
    dsp_write(16'hcafe, 0); dsp_write(16'h1234, 0); tick(); tick();
    checks++;
    if (got.size() != 2) begin errors++; $display("FAIL order_count got %0d want 2", got.size()); end
    else if (got[0] !== 16'hcafe || got[1] !== 16'h1234) begin
      errors++; $display("FAIL order_data got %h %h want cafe 1234", got[0], got[1]);
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL order_ovf got %b want 0", ovf); end
  endtask

  task automatic test_overflow();
    logic [15:0] w[9];
    do_reset(); host_push(16'h5555); hout_ready = 0;
    for (int i = 0; i < 9; i++) begin
      w[i] = 16'($urandom);
      psel = 0; pbus_out = w[i]; pods_n = 0; tick();
      if (i == 0) begin
        checks++; if (hout_valid !== 1'b0) begin errors++; $display("FAIL pre_strobe_valid got %b want 0", hout_valid); end
      end
      pods_n = 1; tick();
      if (i == 0) begin
        checks++; if (hout_valid !== 1'b1) begin errors++; $display("FAIL post_strobe_valid got %b want 1", hout_valid); end
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    psel = 1; #1;
    checks++; if (pbus_in !== 16'h0009) begin errors++; $display("FAIL ovf_status got %h want 0009", pbus_in); end
    dsp_write(16'h0001, 1); psel = 1; #1;
    checks++; if (ovf !== 1'b0 || pbus_in !== 16'h0001) begin errors++; $display("FAIL ovf_clear got ovf=%b st=%h want 0 0001", ovf, pbus_in); end
    // push while full with a simultaneous host pop: still dropped
    psel = 0; pbus_out = 16'habcd; pods_n = 0; tick();
    pods_n = 1; hout_ready = 1; tick(); hout_ready = 0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_pop_ovf got %b want 1", ovf); end
    got.delete(); hout_ready = 1; repeat (10) tick(); hout_ready = 0;
    checks++;
    if (got.size() != 7) begin errors++; $display("FAIL drain_count got %0d want 7", got.size()); end
    else for (int k = 0; k < 7; k++)
      if (got[k] !== w[k+1]) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", k, got[k], w[k+1]); break; end
  endtask

  task automatic test_irq();
    do_reset(); dsp_write(16'h0004, 1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
    host_push(16'hbeef);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq); end
    #1;
    checks++; if (pbus_in !== 16'hbeef) begin errors++; $display("FAIL irq_head got %h want beef", pbus_in); end
    iack = 1; tick(); iack = 0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack got %b want 0", irq); end
    dsp_read(); #1;
    checks++; if (pbus_in !== 16'h0000 || udf !== 1'b0) begin errors++; $display("FAIL irq_read_empty got %h udf=%b want 0000 0", pbus_in, udf); end
    hin_data = 16'h7777; hin_valid = 1; iack = 1; tick(); hin_valid = 0; iack = 0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", irq); end
    iack = 1; tick(); iack = 0; dsp_write(16'h0000, 1); dsp_read(); host_push(16'h0001);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled got %b want 0", irq); end
  endtask

  task automatic test_underflow();
    do_reset(); #1;
    checks++; if (pbus_in !== 16'h0000) begin errors++; $display("FAIL udf_empty_bus got %h want 0000", pbus_in); end
    dsp_read(); #1;
    checks++; if (udf !== 1'b1 || pbus_in !== 16'h0000) begin errors++; $display("FAIL udf_set got udf=%b bus=%h want 1 0000", udf, pbus_in); end
    host_push(16'h4321); #1;
    checks++; if (pbus_in !== 16'h4321) begin errors++; $display("FAIL udf_ptrs got %h want 4321", pbus_in); end
    dsp_read(); psel = 1; #1;
    checks++; if (pbus_in !== 16'h0006) begin errors++; $display("FAIL udf_status got %h want 0006", pbus_in); end
    dsp_write(16'h0002, 1); psel = 1; #1;
    checks++; if (pbus_in !== 16'h0002) begin errors++; $display("FAIL udf_clear got %h want 0002", pbus_in); end
    psel = 0;
  endtask

  task automatic test_wrap_and_reset();
    logic [15:0] w[20];
    logic [15:0] d;
    int bad;
    do_reset(); hout_ready = 1;
    for (int i = 0; i < 20; i++) begin w[i] = 16'($urandom); dsp_write(w[i], 0); end
    tick(); tick();
    checks++; bad = 0;
    if (got.size() != 20) bad = 1;
    else for (int i = 0; i < 20; i++) if (got[i] !== w[i]) bad = 1;
    if (bad) begin errors++; $display("FAIL out_wrap got %0d words (first %h) want 20 (first %h)", got.size(), got.size() ? got[0] : 16'hxxxx, w[0]); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom | 1); host_push(d); #1;
      if (pbus_in !== d && !bad) begin bad = 1; $display("FAIL in_wrap[%0d] got %h want %h", i, pbus_in, d); end
      dsp_read();
    end
    checks++; if (bad) errors++;
    hout_ready = 0;
    for (int i = 0; i < 3; i++) dsp_write(16'h0a00 + 16'(i), 0);
    checks++; if (hout_valid !== 1'b1) begin errors++; $display("FAIL queued_valid got %b want 1", hout_valid); end
    rst = 1; tick(); rst = 0; psel = 1; #1;
    checks++; if (hout_valid !== 1'b0 || pbus_in !== 16'h0002 || {ovf, udf, irq} !== 3'b000) begin
      errors++; $display("FAIL mid_reset got valid=%b st=%h flags=%b want 0 0002 000", hout_valid, pbus_in, {ovf, udf, irq});
    end
    psel = 0; got.delete(); hout_ready = 1; repeat (3) tick(); hout_ready = 0;
    checks++; if (got.size() != 0) begin errors++; $display("FAIL mid_reset_discard got %0d words want 0", got.size()); end
  endtask

  task automatic test_random();
    logic [15:0] exp_bus;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      cen        = ($urandom_range(0, 3) != 0);
      pods_n     = ($urandom_range(0, 2) != 0);
      pids_n     = ($urandom_range(0, 2) != 0);
      psel       = ($urandom_range(0, 3) == 0);
      iack       = ($urandom_range(0, 7) == 0);
      hout_ready = ($urandom_range(0, 2) == 0);
      hin_valid  = ($urandom_range(0, 2) == 0);
      pbus_out   = 16'($urandom);
      hin_data   = 16'($urandom);
      #1;
      if (psel) exp_bus = {12'b0, m_ovf, m_udf, m_in.size() == 0, m_out.size() == DEPTH};
      else exp_bus = (m_in.size() == 0) ? 16'h0000 : m_in[0];
      checks++; if (hout_valid !== (m_out.size() > 0)) begin errors++; $display("FAIL rnd_hout_valid c=%0d got %b want %b", c, hout_valid, m_out.size() > 0); end
      if (m_out.size() > 0) begin
        checks++; if (hout_data !== m_out[0]) begin errors++; $display("FAIL rnd_hout_data c=%0d got %h want %h", c, hout_data, m_out[0]); end
      end
      checks++; if (hin_ready !== (m_in.size() < DEPTH)) begin errors++; $display("FAIL rnd_hin_ready c=%0d got %b want %b", c, hin_ready, m_in.size() < DEPTH); end
      checks++; if ({ovf, udf, irq} !== {m_ovf, m_udf, m_irq}) begin errors++; $display("FAIL rnd_flags c=%0d got %b want %b", c, {ovf, udf, irq}, {m_ovf, m_udf, m_irq}); end
      checks++; if (pbus_in !== exp_bus) begin errors++; $display("FAIL rnd_pbus_in c=%0d got %h want %h", c, pbus_in, exp_bus); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_in_order();
    test_overflow();
    test_irq();
    test_underflow();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
